dmem_arbiter: RTL and testbench

- Shares the single-port data memory (asynchronous read, write on posedge CLK when WE high) between the processor load/store port and a DMA/loader port.
- CPU accesses are single-beat and complete in the cycle they are granted.
- DMA accesses are bursts of 1..16 consecutive words, generated by an internal address/beat counter.
- The block sits between the datapath, the DMA engine and the memory; it drives the memory WE/adrs/WD and returns read data to the granted requester.

---
 rtl/dmem_arbiter_if.sv | 56 +++++
 rtl/dmem_arbiter.sv | 154 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundles the CPU port, the DMA burst port and the memory port of dmem_arbiter.
// Latency: none, this is pure wiring.
// Backpressure: CPU stalls while cpu_gnt is low; the DMA engine holds dma_req until dma_done.
//
// Port summary:
//   cpu_*  : single-beat load/store from the datapath (req/we/adrs/wd in, gnt/rdata out)
//   dma_*  : burst request from the DMA/loader (req/we/adrs/len/wd in, beat/rdata/done out)
//   mem_*  : single-port data memory (we/adrs/wd out, asynchronous rdata in)
//   modport slave  : the arbiter's view
//   modport master : the view of everything around the arbiter (requesters plus memory)
interface dmem_arbiter_if #(
  parameter int dataWidth = 32,
  parameter int lenWidth  = 4
);
  // CPU load/store port
  logic                 cpu_req;
  logic                 cpu_we;
  logic [dataWidth-1:0] cpu_adrs;
  logic [dataWidth-1:0] cpu_wd;
  logic                 cpu_gnt;
  logic [dataWidth-1:0] cpu_rdata;

  // DMA burst port
  logic                 dma_req;
  logic                 dma_we;
  logic [dataWidth-1:0] dma_adrs;
  logic [lenWidth-1:0]  dma_len;
  logic [dataWidth-1:0] dma_wd;
  logic                 dma_beat;
  logic [dataWidth-1:0] dma_rdata;
  logic                 dma_done;

  // Memory port
  logic                 mem_we;
  logic [dataWidth-1:0] mem_adrs;
  logic [dataWidth-1:0] mem_wd;
  logic [dataWidth-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_adrs, cpu_wd,
    output cpu_gnt, cpu_rdata,
    input  dma_req, dma_we, dma_adrs, dma_len, dma_wd,
    output dma_beat, dma_rdata, dma_done,
    output mem_we, mem_adrs, mem_wd,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_adrs, cpu_wd,
    input  cpu_gnt, cpu_rdata,
    output dma_req, dma_we, dma_adrs, dma_len, dma_wd,
    input  dma_beat, dma_rdata, dma_done,
    input  mem_we, mem_adrs, mem_wd,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the CPU load/store port and a DMA burst port.
// Latency: 0 cycles; grants, addresses and read data are combinational, writes commit on the same edge.
// Backpressure: CPU stalls via cpu_gnt=0 when it loses arbitration or a burst is running; bursts are never preempted.
//
// Port summary:
//   CLK  : clock, all state updates on posedge
//   RST  : synchronous active-high reset; forces every grant and memory drive to 0 while high
//   bus  : dmem_arbiter_if.slave carrying the cpu_*, dma_* and mem_* signal groups
module dmem_arbiter #(
  parameter int dataWidth = 32,
  parameter int depth     = 48,
  parameter int lenWidth  = 4
) (
  input  logic           CLK,
  input  logic           RST,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic [dataWidth:0]   DEPTH_EXT = (dataWidth + 1)'(depth);
  localparam logic [dataWidth-1:0] DEPTH_W   = dataWidth'(depth);

  state_t               state_q, state_d;
  logic [lenWidth-1:0]  cnt_q, cnt_d;
  logic [lenWidth-1:0]  len_q, len_d;
  logic [dataWidth-1:0] base_q, base_d;
  logic                 we_q, we_d;
  // 0 = CPU had the last access, 1 = DMA did; the other side wins the next tie.
  logic                 last_owner_q, last_owner_d;

  logic                 cpu_win;
  logic                 dma_win;
  logic [dataWidth:0]   beat_sum;
  logic [dataWidth-1:0] beat_adrs;

  // Burst beat address. base < depth and cnt < 2^lenWidth, so a single
  // conditional subtract is enough to wrap modulo depth. The extra sum bit
  // keeps the comparison exact; the subtraction only needs the low bits.
  always_comb begin
    beat_sum = {1'b0, base_q} + (dataWidth + 1)'(cnt_q);
    if (beat_sum >= DEPTH_EXT) begin
      beat_adrs = beat_sum[dataWidth-1:0] - DEPTH_W;
    end else begin
      beat_adrs = beat_sum[dataWidth-1:0];
    end
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      len_q        <= '0;
      base_q       <= '0;
      we_q         <= 1'b0;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      base_q       <= base_d;
      we_q         <= we_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Arbitration, next state and all outputs
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    base_d       = base_q;
    we_d         = we_q;
    last_owner_d = last_owner_q;

    cpu_win = 1'b0;
    dma_win = 1'b0;

    bus.cpu_gnt   = 1'b0;
    bus.cpu_rdata = '0;
    bus.dma_beat  = 1'b0;
    bus.dma_rdata = '0;
    bus.dma_done  = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_adrs  = '0;
    bus.mem_wd    = '0;

    // During reset the register block discards the next-state values, so
    // only the outputs need suppressing here.
    if (!RST) begin
      unique case (state_q)
        IDLE: begin
          // Round-robin: on a tie the side that did not own the memory last wins.
          cpu_win = bus.cpu_req && (!bus.dma_req || last_owner_q);
          dma_win = bus.dma_req && (!bus.cpu_req || !last_owner_q);

          if (cpu_win) begin
            bus.cpu_gnt   = 1'b1;
            bus.cpu_rdata = bus.mem_rdata;
            bus.mem_we    = bus.cpu_we;
            bus.mem_adrs  = bus.cpu_adrs;
            bus.mem_wd    = bus.cpu_wd;
            last_owner_d  = 1'b0;
          end else if (dma_win) begin
            // Beat 0 goes straight out at dma_adrs; the burst parameters are
            // captured now so later changes on the DMA inputs are ignored.
            bus.dma_beat  = 1'b1;
            bus.dma_rdata = bus.mem_rdata;
            bus.mem_we    = bus.dma_we;
            bus.mem_adrs  = bus.dma_adrs;
            bus.mem_wd    = bus.dma_wd;
            base_d        = bus.dma_adrs;
            len_d         = bus.dma_len;
            we_d          = bus.dma_we;
            last_owner_d  = 1'b1;
            if (bus.dma_len == '0) begin
              bus.dma_done = 1'b1;
            end else begin
              cnt_d   = lenWidth'(1);
              state_d = BURST;
            end
          end
        end

        BURST: begin
          // DMA owns the memory unconditionally; dma_req may drop mid-burst.
          bus.dma_beat  = 1'b1;
          bus.dma_rdata = bus.mem_rdata;
          bus.mem_we    = we_q;
          bus.mem_adrs  = beat_adrs;
          bus.mem_wd    = bus.dma_wd;
          if (cnt_q == len_q) begin
            // last_owner is already 1, so the CPU wins the next tie.
            bus.dma_done = 1'b1;
            cnt_d        = '0;
            state_d      = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural 48-word memory.
// Latency: checks are taken 1 time unit after the falling edge, before the commit edge.
// Backpressure: stimulus is directed; cpu_gnt/dma_beat expectations are hand-computed per cycle.
module tb_dmem_arbiter;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  dmem_arbiter_if #(.dataWidth(32), .lenWidth(4)) bus();

  dmem_arbiter #(.dataWidth(32), .depth(48), .lenWidth(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // Single-port memory: asynchronous read, write on posedge when mem_we.
  logic [31:0] mem [48];

  always @(posedge CLK) begin
    if (bus.mem_we && bus.mem_adrs < 32'd48) mem[bus.mem_adrs[5:0]] <= bus.mem_wd;
  end

  always_comb begin
    if (bus.mem_adrs < 32'd48) bus.mem_rdata = mem[bus.mem_adrs[5:0]];
    else                       bus.mem_rdata = '0;
  end

  typedef struct {
    logic        rst;
    logic        creq, cwe;
    logic [31:0] cadr, cwd;
    logic        dreq, dwe;
    logic [31:0] dadr;
    logic [3:0]  dlen;
    logic [31:0] dwd;
    logic        ecg, edb, edd, ewe;
    logic [31:0] eadr, ewd;
    logic        ccr;
    logic [31:0] ecrd;
    logic        cdr;
    logic [31:0] edrd;
  } vec_t;

  vec_t tbl[$];
  int   tests = 0;
  int   fails = 0;

  // One cycle: reset, CPU inputs, DMA inputs, then expected outputs and read-data checks.
  function automatic vec_t row(
    input logic [31:0] rst, creq, cwe, cadr, cwd,
    input logic [31:0] dreq, dwe, dadr, dlen, dwd,
    input logic [31:0] ecg, edb, edd, ewe, eadr, ewd,
    input logic [31:0] ccr, ecrd, cdr, edrd);
    vec_t r;
    r.rst  = rst[0];
    r.creq = creq[0]; r.cwe = cwe[0]; r.cadr = cadr; r.cwd = cwd;
    r.dreq = dreq[0]; r.dwe = dwe[0]; r.dadr = dadr; r.dlen = dlen[3:0]; r.dwd = dwd;
    r.ecg  = ecg[0];  r.edb = edb[0]; r.edd = edd[0]; r.ewe = ewe[0];
    r.eadr = eadr;    r.ewd = ewd;
    r.ccr  = ccr[0];  r.ecrd = ecrd;
    r.cdr  = cdr[0];  r.edrd = edrd;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    @(negedge CLK);
    RST          = v.rst;
    bus.cpu_req  = v.creq;
    bus.cpu_we   = v.cwe;
    bus.cpu_adrs = v.cadr;
    bus.cpu_wd   = v.cwd;
    bus.dma_req  = v.dreq;
    bus.dma_we   = v.dwe;
    bus.dma_adrs = v.dadr;
    bus.dma_len  = v.dlen;
    bus.dma_wd   = v.dwd;
    #1;
    chk({tag, ".cpu_gnt"},  32'(bus.cpu_gnt),  32'(v.ecg));
    chk({tag, ".dma_beat"}, 32'(bus.dma_beat), 32'(v.edb));
    chk({tag, ".dma_done"}, 32'(bus.dma_done), 32'(v.edd));
    chk({tag, ".mem_we"},   32'(bus.mem_we),   32'(v.ewe));
    chk({tag, ".mem_adrs"}, bus.mem_adrs,      v.eadr);
    if (v.ewe || v.rst) chk({tag, ".mem_wd"}, bus.mem_wd, v.ewd);
    if (v.ccr)          chk({tag, ".cpu_rdata"}, bus.cpu_rdata, v.ecrd);
    else if (!v.ecg)    chk({tag, ".cpu_rdata_idle"}, bus.cpu_rdata, 32'h0);
    if (v.cdr)          chk({tag, ".dma_rdata"}, bus.dma_rdata, v.edrd);
    else if (!v.edb)    chk({tag, ".dma_rdata_idle"}, bus.dma_rdata, 32'h0);
  endtask

  initial begin
    vec_t v;
    int   stall;

    RST = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_adrs = '0; bus.cpu_wd = '0;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_adrs = '0; bus.dma_len = '0; bus.dma_wd = '0;

    // ---------------- table-driven main sequence ----------------
    // reset with both sides requesting: everything must stay quiet
    tbl.push_back(row(1, 1,1,5,32'h1111,  1,1,7,3,32'h2222,  0,0,0,0,0,0,  0,0,0,0));
    tbl.push_back(row(1, 1,1,5,32'h1111,  1,1,7,3,32'h2222,  0,0,0,0,0,0,  0,0,0,0));
    // CPU write then read of address 5
    tbl.push_back(row(0, 1,1,5,32'hDEADBEEF, 0,0,0,0,0,  1,0,0,1,5,32'hDEADBEEF,  0,0,0,0));
    tbl.push_back(row(0, 1,0,5,0,            0,0,0,0,0,  1,0,0,0,5,0,  1,32'hDEADBEEF,0,0));
    // preload the wrap region through the CPU port
    tbl.push_back(row(0, 1,1,46,32'hA5A5002E, 0,0,0,0,0,  1,0,0,1,46,32'hA5A5002E,  0,0,0,0));
    tbl.push_back(row(0, 1,1,47,32'hA5A5002F, 0,0,0,0,0,  1,0,0,1,47,32'hA5A5002F,  0,0,0,0));
    tbl.push_back(row(0, 1,1,0, 32'hA5A50000, 0,0,0,0,0,  1,0,0,1,0, 32'hA5A50000,  0,0,0,0));
    tbl.push_back(row(0, 1,1,1, 32'hA5A50001, 0,0,0,0,0,  1,0,0,1,1, 32'hA5A50001,  0,0,0,0));
    // nobody requesting
    tbl.push_back(row(0, 0,0,0,0,  0,0,0,0,0,  0,0,0,0,0,0,  0,0,0,0));
    // DMA write burst base 10 len 3; mid-burst CPU request, changed DMA fields and dropped req are ignored
    tbl.push_back(row(0, 0,0,0,0,          1,1,10,3,1,  0,1,0,1,10,1,  0,0,0,0));
    tbl.push_back(row(0, 1,1,20,32'hBAD,   1,0,33,0,2,  0,1,0,1,11,2,  0,0,0,0));
    tbl.push_back(row(0, 0,0,0,0,          0,0,0,0,3,   0,1,0,1,12,3,  0,0,0,0));
    tbl.push_back(row(0, 0,0,0,0,          1,1,10,3,4,  0,1,1,1,13,4,  0,0,0,0));
    // CPU reads back burst data
    tbl.push_back(row(0, 1,0,12,0,  0,0,0,0,0,  1,0,0,0,12,0,  1,3,0,0));
    tbl.push_back(row(0, 1,0,11,0,  0,0,0,0,0,  1,0,0,0,11,0,  1,2,0,0));
    tbl.push_back(row(0, 1,0,13,0,  0,0,0,0,0,  1,0,0,0,13,0,  1,4,0,0));
    // DMA read burst base 46 len 3 wraps to 0
    tbl.push_back(row(0, 0,0,0,0,  1,0,46,3,0,  0,1,0,0,46,0,  0,0,1,32'hA5A5002E));
    tbl.push_back(row(0, 0,0,0,0,  1,0,46,3,0,  0,1,0,0,47,0,  0,0,1,32'hA5A5002F));
    tbl.push_back(row(0, 0,0,0,0,  1,0,46,3,0,  0,1,0,0,0, 0,  0,0,1,32'hA5A50000));
    tbl.push_back(row(0, 0,0,0,0,  1,0,46,3,0,  0,1,1,0,1, 0,  0,0,1,32'hA5A50001));
    // continuous CPU reads vs single-beat DMA reads: strict alternation, CPU first after the burst
    for (int i = 0; i < 3; i++) begin
      tbl.push_back(row(0, 1,0,5,0,  1,0,12,0,0,  1,0,0,0,5,0,   1,32'hDEADBEEF,0,0));
      tbl.push_back(row(0, 1,0,5,0,  1,0,12,0,0,  0,1,1,0,12,0,  0,0,1,3));
    end
    tbl.push_back(row(0, 0,0,0,0,  0,0,0,0,0,  0,0,0,0,0,0,  0,0,0,0));

    foreach (tbl[i]) step(tbl[i], $sformatf("v%0d", i));

    // ---------------- contention straight out of reset ----------------
    step(row(1, 1,0,5,0,  1,1,40,1,32'h77,  0,0,0,0,0,0,  0,0,0,0), "cont.rst");
    stall = 0;
    step(row(0, 1,0,5,0,  1,1,40,1,32'h77,  1,0,0,0,5,0,     1,32'hDEADBEEF,0,0), "cont.c0");
    stall += bus.cpu_gnt ? 0 : 1;
    step(row(0, 1,0,5,0,  1,1,40,1,32'h77,  0,1,0,1,40,32'h77,  0,0,0,0), "cont.c1");
    stall += bus.cpu_gnt ? 0 : 1;
    step(row(0, 1,0,5,0,  1,1,40,1,32'h78,  0,1,1,1,41,32'h78,  0,0,0,0), "cont.c2");
    stall += bus.cpu_gnt ? 0 : 1;
    step(row(0, 1,0,5,0,  1,1,40,1,32'h79,  1,0,0,0,5,0,     1,32'hDEADBEEF,0,0), "cont.c3");
    stall += bus.cpu_gnt ? 0 : 1;
    chk("cont.stall_cycles", 32'(stall), 32'd2);
    step(row(0, 1,0,40,0,  0,0,0,0,0,  1,0,0,0,40,0,  1,32'h77,0,0), "cont.rd40");

    // ---------------- reset on beat 2 of a len-7 write burst ----------------
    step(row(0, 0,0,0,0,  1,1,20,7,32'h100,  0,1,0,1,20,32'h100,  0,0,0,0), "rstb.b0");
    step(row(0, 0,0,0,0,  1,1,20,7,32'h101,  0,1,0,1,21,32'h101,  0,0,0,0), "rstb.b1");
    step(row(1, 0,0,0,0,  1,1,20,7,32'h102,  0,0,0,0,0,0,  0,0,0,0), "rstb.r0");
    step(row(1, 0,0,0,0,  1,1,20,7,32'h103,  0,0,0,0,0,0,  0,0,0,0), "rstb.r1");
    for (int b = 0; b < 8; b++) begin
      v = row(0, 0,0,0,0,  1,1,20,7,32'h200 + b,
              0,1,(b == 7) ? 1 : 0,1,20 + b,32'h200 + b,  0,0,0,0);
      step(v, $sformatf("rstb.n%0d", b));
    end
    step(row(0, 1,0,22,0,  0,0,0,0,0,  1,0,0,0,22,0,  1,32'h202,0,0), "rstb.rd22");
    step(row(0, 1,0,27,0,  0,0,0,0,0,  1,0,0,0,27,0,  1,32'h207,0,0), "rstb.rd27");
    step(row(0, 0,0,0,0,   0,0,0,0,0,  0,0,0,0,0,0,  0,0,0,0), "rstb.idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
